fp32_compare: RTL and testbench

FP32_COMPARE -- requirements
Module: fp32_compare

---
 rtl/fp32_compare_pkg.sv | 39 +++
 rtl/fp32_classify.sv | 19 +
 rtl/fp32_compare.sv | 75 +++++++
 tb/tb_fp32_compare.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fp32_compare_pkg.sv
// fp32_compare_pkg: FP32 field widths, exponent constants, compare operator codes
// and the stage-1 register layout shared by the comparator files.
package fp32_compare_pkg;
    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int HI_W  = 16;
    localparam int LO_W  = 15;
    localparam logic [EXP_W-1:0] EXP_ONES  = '1;
    localparam logic [EXP_W-1:0] EXP_ZEROS = '0;
    localparam int OP_GT = 0;
    localparam int OP_LT = 1;
    localparam int OP_EQ = 2;
    localparam int OP_GE = 3;
    localparam int OP_LE = 4;
    localparam int OP_NE = 5;

    typedef struct packed {
        logic nan_a;
        logic nan_b;
        logic zero_a;
        logic zero_b;
        logic sign_a;
        logic sign_b;
        logic hi_gt;
        logic hi_eq;
        logic lo_gt;
        logic lo_eq;
    } stage1_t;

    function automatic logic apply_op(input int op, input logic gt, input logic eq);
        return op == OP_GT ? gt :
               op == OP_LT ? ~gt & ~eq :
               op == OP_EQ ? eq :
               op == OP_GE ? gt | eq :
               op == OP_LE ? ~gt :
               ~eq;
    endfunction
endpackage

// File: rtl/fp32_classify.sv
// fp32_classify: per-operand NaN / zero / sign detection, with optional
// flushing of subnormals to zero.
module fp32_classify import fp32_compare_pkg::*; #(
    parameter int FLUSH_DENORM = 1
) (
    input  logic [FP_W-1:0] i_x,
    output logic            o_nan,
    output logic            o_zero,
    output logic            o_sign
);
    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;

    assign exp_f  = i_x[FP_W-2 -: EXP_W];
    assign man_f  = i_x[MAN_W-1:0];
    assign o_nan  = exp_f == EXP_ONES && man_f != '0;
    assign o_zero = exp_f == EXP_ZEROS && (man_f == '0 || FLUSH_DENORM != 0);
    assign o_sign = i_x[FP_W-1];
endmodule

// File: rtl/fp32_compare.sv
// fp32_compare: two-stage pipelined IEEE-754 binary32 comparator; stage 1
// classifies operands and splits the magnitude compare, stage 2 orders and applies OP.
module fp32_compare import fp32_compare_pkg::*; #(
    parameter int OP           = 0,
    parameter int FLUSH_DENORM = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_a_valid,
    input  logic [FP_W-1:0] i_a,
    input  logic            i_b_valid,
    input  logic [FP_W-1:0] i_b,
    output logic            o_result_valid,
    output logic [7:0]      o_result,
    output logic            o_unordered
);
    logic            nan_a, nan_b, zero_a, zero_b, sign_a, sign_b;
    logic [HI_W-1:0] hi_a, hi_b;
    logic [LO_W-1:0] lo_a, lo_b;
    stage1_t         s1_d, s1_q;
    logic            v1_q, v2_q, res_d, res_q, unord_d, unord_q;
    logic            nan, mag_gt, mag_eq, neg_a, neg_b, eq, gt;

    fp32_classify #(.FLUSH_DENORM(FLUSH_DENORM)) u_cls_a (
        .i_x(i_a), .o_nan(nan_a), .o_zero(zero_a), .o_sign(sign_a)
    );
    fp32_classify #(.FLUSH_DENORM(FLUSH_DENORM)) u_cls_b (
        .i_x(i_b), .o_nan(nan_b), .o_zero(zero_b), .o_sign(sign_b)
    );

    assign hi_a = i_a[FP_W-2 -: HI_W];
    assign hi_b = i_b[FP_W-2 -: HI_W];
    assign lo_a = i_a[LO_W-1:0];
    assign lo_b = i_b[LO_W-1:0];

    always_comb begin
        s1_d = '{nan_a: nan_a, nan_b: nan_b, zero_a: zero_a, zero_b: zero_b,
                 sign_a: sign_a, sign_b: sign_b,
                 hi_gt: hi_a > hi_b, hi_eq: hi_a == hi_b,
                 lo_gt: lo_a > lo_b, lo_eq: lo_a == lo_b};
    end

    // A zero (incl. flushed subnormal) counts as non-negative so +0 == -0.
    always_comb begin
        nan     = s1_q.nan_a | s1_q.nan_b;
        mag_gt  = s1_q.hi_gt | (s1_q.hi_eq & s1_q.lo_gt);
        mag_eq  = s1_q.hi_eq & s1_q.lo_eq;
        neg_a   = s1_q.sign_a & ~s1_q.zero_a;
        neg_b   = s1_q.sign_b & ~s1_q.zero_b;
        eq      = (s1_q.zero_a & s1_q.zero_b) | (neg_a == neg_b && mag_eq);
        gt      = ~eq & (neg_a != neg_b ? neg_b : (neg_a ? ~mag_gt : mag_gt));
        res_d   = v1_q & (nan ? OP == OP_NE : apply_op(OP, gt, eq));
        unord_d = v1_q & nan;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1_q    <= 1'b0;
            s1_q    <= '0;
            v2_q    <= 1'b0;
            res_q   <= 1'b0;
            unord_q <= 1'b0;
        end else begin
            v1_q    <= i_a_valid & i_b_valid;
            s1_q    <= s1_d;
            v2_q    <= v1_q;
            res_q   <= res_d;
            unord_q <= unord_d;
        end
    end

    assign o_result_valid = v2_q;
    assign o_result       = {7'b0, res_q};
    assign o_unordered    = unord_q;
endmodule

// File: tb/tb_fp32_compare.sv
// tb_fp32_compare: directed checks of all six OP variants side by side,
// driving inputs on the falling edge and sampling outputs on the falling edge.
module tb_fp32_compare;
    localparam int NV = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0;
    logic        b_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        rv [6];
    logic [7:0]  res [6];
    logic        un [6];
    int          checks = 0;
    int          errors = 0;

    // Expected bit k is the comparison result for OP=k (gt,lt,eq,ge,le,ne).
    logic [31:0] tab_a [NV] = '{32'h40000000, 32'h00000000, 32'hC0000000, 32'hFF800000,
                                32'h7FC00000, 32'h7F800000, 32'h00000001, 32'h3F800000,
                                32'hBF800000, 32'h40000000, 32'h3F800000, 32'h3F800000,
                                32'h7F800000, 32'h00000002, 32'h80000005, 32'hFF7FFFFF};
    logic [31:0] tab_b [NV] = '{32'h3F800000, 32'h80000000, 32'hBF800000, 32'hFF7FFFFF,
                                32'h3F800000, 32'h7F800000, 32'h80000000, 32'h3F800001,
                                32'h40000000, 32'h80000000, 32'h3F7FFFFF, 32'hFFC00000,
                                32'h7F800001, 32'h00000001, 32'h00800000, 32'hFF800000};
    logic [5:0]  tab_e [NV] = '{6'b101001, 6'b011100, 6'b110010, 6'b110010,
                                6'b100000, 6'b011100, 6'b011100, 6'b110010,
                                6'b110010, 6'b101001, 6'b101001, 6'b100000,
                                6'b100000, 6'b011100, 6'b110010, 6'b101001};
    logic        tab_u [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    for (genvar k = 0; k < 6; k++) begin : g_dut
        fp32_compare #(.OP(k), .FLUSH_DENORM(1)) u_dut (
            .i_clk(clk), .i_rst_n(rst_n),
            .i_a_valid(a_valid), .i_a(a),
            .i_b_valid(b_valid), .i_b(b),
            .o_result_valid(rv[k]), .o_result(res[k]), .o_unordered(un[k])
        );
    end

    task automatic test_reset();
        a = 32'h40000000; b = 32'h3F800000; a_valid = 1'b1; b_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            for (int k = 0; k < 6; k++) begin
                checks++;
                if ({rv[k], un[k], res[k]} !== 10'b0) begin
                    errors++;
                    $display("FAIL reset_state op%0d: got v=%b u=%b r=%h want 0", k, rv[k], un[k], res[k]);
                end
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (rv[k] !== 1'b0) begin
                errors++;
                $display("FAIL first_pair_early op%0d: got v=%b want 0", k, rv[k]);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({rv[k], un[k], res[k]} !== {1'b1, 1'b0, 7'b0, tab_e[0][k]}) begin
                errors++;
                $display("FAIL first_pair op%0d: got v=%b u=%b r=%h want v=1 u=0 r=%0d", k, rv[k], un[k], res[k], tab_e[0][k]);
            end
        end
    endtask

    task automatic test_directed();
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            a = tab_a[i]; b = tab_b[i]; a_valid = 1'b1; b_valid = 1'b1;
            @(negedge clk);
            a_valid = 1'b0; b_valid = 1'b0;
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (rv[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL latency vec%0d op%0d: got v=%b want 0 one cycle after accept", i, k, rv[k]);
                end
            end
            @(negedge clk);
            for (int k = 0; k < 6; k++) begin
                checks++;
                if ({rv[k], un[k], res[k]} !== {1'b1, tab_u[i], 7'b0, tab_e[i][k]}) begin
                    errors++;
                    $display("FAIL vec%0d op%0d a=%h b=%h: got v=%b u=%b r=%h want v=1 u=%b r=%0d",
                             i, k, tab_a[i], tab_b[i], rv[k], un[k], res[k], tab_u[i], tab_e[i][k]);
                end
            end
        end
    endtask

    task automatic test_single_valid();
        @(negedge clk);
        a = 32'h40000000; b = 32'h3F800000; a_valid = 1'b1; b_valid = 1'b0;
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 6; k++) begin
                checks++;
                if ({rv[k], un[k], res[k]} !== 10'b0) begin
                    errors++;
                    $display("FAIL single_valid op%0d: got v=%b u=%b r=%h want 0", k, rv[k], un[k], res[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int  seen = 0;
        int  j;
        logic exp_v;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                j = i - 2;
                exp_v = (j != 3);
                for (int k = 0; k < 6; k++) begin
                    checks++;
                    if (rv[k] !== exp_v || (exp_v && (res[k] !== {7'b0, tab_e[j][k]} || un[k] !== tab_u[j]))
                        || (!exp_v && (res[k] !== 8'h00 || un[k] !== 1'b0))) begin
                        errors++;
                        $display("FAIL b2b slot%0d op%0d: got v=%b u=%b r=%h want v=%b u=%b r=%0d",
                                 j, k, rv[k], un[k], res[k], exp_v, exp_v & tab_u[j], exp_v & tab_e[j][k]);
                    end
                end
                if (rv[0] === 1'b1) seen++;
            end
            if (i < 8) begin
                a = tab_a[i]; b = tab_b[i]; a_valid = 1'b1; b_valid = (i != 3);
            end else begin
                a_valid = 1'b0; b_valid = 1'b0;
            end
        end
        checks++;
        if (seen != 7) begin
            errors++;
            $display("FAIL b2b_count: got %0d results want 7", seen);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        a = tab_a[0]; b = tab_b[0]; a_valid = 1'b1; b_valid = 1'b1;
        @(negedge clk);
        a = tab_a[2]; b = tab_b[2];
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({rv[k], un[k], res[k]} !== 10'b0) begin
                errors++;
                $display("FAIL mid_reset_async op%0d: got v=%b u=%b r=%h want 0", k, rv[k], un[k], res[k]);
            end
        end
        repeat (2) begin
            @(negedge clk);
            for (int k = 0; k < 6; k++) begin
                checks++;
                if ({rv[k], un[k], res[k]} !== 10'b0) begin
                    errors++;
                    $display("FAIL mid_reset_hold op%0d: got v=%b u=%b r=%h want 0", k, rv[k], un[k], res[k]);
                end
            end
        end
        rst_n = 1'b1;
        a = tab_a[4]; b = tab_b[4];
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (rv[k] !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_early op%0d: got v=%b want 0", k, rv[k]);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({rv[k], un[k], res[k]} !== {1'b1, tab_u[4], 7'b0, tab_e[4][k]}) begin
                errors++;
                $display("FAIL post_reset_pair op%0d: got v=%b u=%b r=%h want v=1 u=%b r=%0d",
                         k, rv[k], un[k], res[k], tab_u[4], tab_e[4][k]);
            end
        end
        repeat (2) begin
            @(negedge clk);
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (rv[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL post_reset_stray op%0d: got v=%b want 0", k, rv[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_single_valid();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
